// File: rtl/hash_cmd_pkg.sv
// Shared definitions for the hash-table command path: FSM states, op codes, width helpers.
package hash_cmd_pkg;

  typedef enum logic {
    ASSEMBLE = 1'b0,
    DISCARD  = 1'b1
  } state_e;

  localparam logic [1:0] OP_DELETE = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;

  function automatic int calc_cmd_width(input int key_w, input int data_w);
    return 2 + key_w + data_w;
  endfunction

  function automatic int calc_beats(input int cmd_w, input int in_w);
    return (cmd_w + in_w - 1) / in_w;
  endfunction

endpackage

// File: rtl/hash_cmd_assembler_if.sv
// Host beat stream in, assembled command out, plus error reporting, for hash_cmd_assembler.
interface hash_cmd_assembler_if
  import hash_cmd_pkg::*;
#(
  parameter int KEY_WIDTH     = 5,
  parameter int DATA_WIDTH    = 25,
  parameter int IN_WIDTH      = 8,
  parameter int CMD_WIDTH     = calc_cmd_width(KEY_WIDTH, DATA_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
);

  logic [IN_WIDTH-1:0]      s_data_i;
  logic                     s_valid_i;
  logic                     s_last_i;
  logic                     s_ready_o;
  logic [CMD_WIDTH-1:0]     m_data_o;
  logic                     m_valid_o;
  logic                     m_last_o;
  logic                     m_ready_i;
  logic                     err_short_o;
  logic                     err_long_o;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o, m_last_o,
           err_short_o, err_long_o, err_cnt_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o,
           err_short_o, err_long_o, err_cnt_o
  );

endinterface

// File: rtl/hash_cmd_assembler.sv
// Packs little-endian beats into one {op,key,data} command; output one cycle after the last beat.
// Stalls the final beat only while a held command is not drained; short/long frames are flagged.
module hash_cmd_assembler
  import hash_cmd_pkg::*;
#(
  parameter int KEY_WIDTH     = 5,
  parameter int DATA_WIDTH    = 25,
  parameter int IN_WIDTH      = 8,
  parameter int CMD_WIDTH     = calc_cmd_width(KEY_WIDTH, DATA_WIDTH),
  parameter int BEATS         = calc_beats(CMD_WIDTH, IN_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hash_cmd_assembler_if.slave  bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]     asm_q, asm_d;
  logic [CMD_WIDTH-1:0]     m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     err_short_q, err_short_d;
  logic                     err_long_q, err_long_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic                     s_ready;
  logic                     accept;
  logic                     err_inc;
  logic [CMD_WIDTH-1:0]     merged;

  always_comb begin
    if (reset) begin
      s_ready = 1'b0;
    end else if (state_q == DISCARD) begin
      s_ready = 1'b1;
    end else begin
      s_ready = !(cnt_q == LAST_CNT && m_valid_q && !bus.m_ready_i);
    end
  end

  assign accept = bus.s_valid_i && s_ready;

  // Current beat overlaid on the partial word; bits past CMD_WIDTH are simply never mapped.
  always_comb begin
    merged = asm_q;
    for (int b = 0; b < CMD_WIDTH; b++) begin
      if ((b / IN_WIDTH) == int'(cnt_q)) begin
        merged[b] = bus.s_data_i[b % IN_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !bus.m_ready_i;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_inc     = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ASSEMBLE: begin
        if (accept) begin
          if (cnt_q != LAST_CNT) begin
            if (bus.s_last_i) begin
              cnt_d       = '0;
              asm_d       = '0;
              err_short_d = 1'b1;
              err_inc     = 1'b1;
            end else begin
              asm_d = merged;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            m_data_d  = merged;
            m_valid_d = 1'b1;
            cnt_d     = '0;
            asm_d     = '0;
            if (!bus.s_last_i) begin
              err_long_d = 1'b1;
              err_inc    = 1'b1;
              state_d    = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (accept && bus.s_last_i) begin
          state_d = ASSEMBLE;
        end
      end
      default: state_d = ASSEMBLE;
    endcase

    if (err_inc && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ASSEMBLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.s_ready_o   = s_ready;
  assign bus.m_data_o    = m_data_q;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_last_o    = m_valid_q;
  assign bus.err_short_o = err_short_q;
  assign bus.err_long_o  = err_long_q;
  assign bus.err_cnt_o   = err_cnt_q;

endmodule
